mem_sync_dp: RTL and testbench

// - Parametrised successor of the single-port synchronous RAM. Port A reads/writes with byte enables; port B is read-only.
// - Built-in init sequencer clears the array after reset. Selectable read-during-write mode and optional output register.
// - General-purpose on-chip buffer for datapath and descriptor storage.

---
 rtl/mem_sync_pkg.sv | 19 +
 rtl/mem_sync_dp_array.sv | 66 ++++++
 rtl/mem_sync_dp.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_sync_dp.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sync_pkg.sv
// Purpose : shared types and helpers for the mem_sync_dp dual-port RAM.
// Latency : n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package mem_sync_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Even parity: the stored bit makes the 9-bit lane have an even number of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/mem_sync_dp_array.sv
// Purpose : raw 1W2R word storage with per-lane write enables and read-during-write muxing.
// Latency : reads registered, data on the cycle after ra_en/rb_en.
// Backpressure: none; the read registers hold their value when the enable is low.
// Ports   : clk; write port we/waddr/wbe/wdat; read ports ra_en/ra_addr/ra_dat, rb_en/rb_addr/rb_dat.
//           Lanes are LW bits wide (a byte, plus a parity bit when the top stores parity).
module mem_sync_dp_array
  import mem_sync_pkg::*;
#(
  parameter int NL       = 2,
  parameter int LW       = 8,
  parameter int DEPTH    = 256,
  parameter int AW       = 8,
  parameter int RDW_MODE = RDW_READ_FIRST
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [NL-1:0]    wbe,
  input  logic [NL*LW-1:0] wdat,
  input  logic             ra_en,
  input  logic [AW-1:0]    ra_addr,
  input  logic             rb_en,
  input  logic [AW-1:0]    rb_addr,
  output logic [NL*LW-1:0] ra_dat,
  output logic [NL*LW-1:0] rb_dat
);

  localparam int WW = NL * LW;

  logic [WW-1:0] mem [DEPTH];
  logic [WW-1:0] merged;
  logic [WW-1:0] ra_dat_d, ra_dat_q, rb_dat_d, rb_dat_q;
  logic          fwd_a, fwd_b;

  // Post-write image of the word being written, used for write-first reads.
  always_comb begin
    merged = mem[waddr];
    for (int l = 0; l < NL; l++) begin
      if (wbe[l]) merged[l*LW +: LW] = wdat[l*LW +: LW];
    end
  end

  assign fwd_a = (RDW_MODE == RDW_WRITE_FIRST) && we && (waddr == ra_addr);
  assign fwd_b = (RDW_MODE == RDW_WRITE_FIRST) && we && (waddr == rb_addr);

  always_comb begin
    ra_dat_d = ra_dat_q;
    rb_dat_d = rb_dat_q;
    if (ra_en) ra_dat_d = fwd_a ? merged : mem[ra_addr];
    if (rb_en) rb_dat_d = fwd_b ? merged : mem[rb_addr];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < NL; l++) begin
        if (wbe[l]) mem[waddr][l*LW +: LW] <= wdat[l*LW +: LW];
      end
    end
    ra_dat_q <= ra_dat_d;
    rb_dat_q <= rb_dat_d;
  end

  assign ra_dat = ra_dat_q;
  assign rb_dat = rb_dat_q;

endmodule

// File: rtl/mem_sync_dp.sv
// Purpose : dual-port sync RAM (A: r/w with byte enables, B: read-only) with an init sweep after reset.
// Latency : read data and rvalid 1 cycle after acceptance, 2 with OUT_REG=1; fully pipelined.
// Backpressure: none; requests are dropped while ready=0 (init sweep in progress).
// Ports   : clk, rst (sync, active-high), ready; A: a_en a_wen a_be a_addr a_wd -> a_rd a_rvalid;
//           B: b_en b_addr -> b_rd b_rvalid; addr_err pulses for any accepted address >= DEPTH.
//           MEM_SYNC_DP_PARITY_EN adds per-byte even parity with par_inj, a_perr, b_perr.
module mem_sync_dp
  import mem_sync_pkg::*;
#(
  parameter int            DW       = 16,
  parameter int            DEPTH    = 256,
  parameter int            AW       = $clog2(DEPTH),
  parameter int            RDW_MODE = RDW_READ_FIRST,
  parameter int            OUT_REG  = 0,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              a_en,
  input  logic              a_wen,
  input  logic [DW/8-1:0]   a_be,
  input  logic [AW-1:0]     a_addr,
  input  logic [DW-1:0]     a_wd,
  output logic [DW-1:0]     a_rd,
  output logic              a_rvalid,
  input  logic              b_en,
  input  logic [AW-1:0]     b_addr,
  output logic [DW-1:0]     b_rd,
  output logic              b_rvalid,
`ifdef MEM_SYNC_DP_PARITY_EN
  input  logic              par_inj,
  output logic              a_perr,
  output logic              b_perr,
`endif
  output logic              addr_err
);

  localparam int NB = DW / 8;
`ifdef MEM_SYNC_DP_PARITY_EN
  localparam int LW = 9;
`else
  localparam int LW = 8;
`endif
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             a_oob, b_oob, a_acc, b_acc, a_rreq;
  logic             init_we, user_we, we;
  logic [AW-1:0]    waddr, ra_addr, rb_addr;
  logic [NB-1:0]    wbe;
  logic [DW-1:0]    wsrc;
  logic [NB*LW-1:0] wdat, ra_dat, rb_dat;
  // Stage 1: valid, and "force zero" (out-of-range or post-reset) per port.
  logic             a_v1_q, a_v1_d, b_v1_q, b_v1_d;
  logic             a_z1_q, a_z1_d, b_z1_q, b_z1_d;
  logic             addr_err_q, addr_err_d;
  logic [DW-1:0]    a_s1, b_s1;
`ifdef MEM_SYNC_DP_PARITY_EN
  logic             a_pe1, b_pe1;
`endif

  assign ready   = (state_q == ST_READY);
  assign a_oob   = {1'b0, a_addr} >= DEPTH_W;
  assign b_oob   = {1'b0, b_addr} >= DEPTH_W;
  // Gating with rst keeps a request in the reset cycle from touching the array.
  assign a_acc   = a_en & ready & ~rst;
  assign b_acc   = b_en & ready & ~rst;
  // A write with no byte enables is a no-op and returns nothing.
  assign a_rreq  = a_acc & (~a_wen | (|a_be));
  assign init_we = (state_q == ST_INIT);
  assign user_we = a_acc & a_wen & (|a_be) & ~a_oob;
  assign we      = init_we | user_we;
  // Out-of-range addresses are steered to word 0; their data is zeroed later.
  assign ra_addr = a_oob ? '0 : a_addr;
  assign rb_addr = b_oob ? '0 : b_addr;
  assign waddr   = init_we ? cnt_q : ra_addr;
  assign wbe     = init_we ? '1 : a_be;
  assign wsrc    = init_we ? INIT_VAL : a_wd;

  always_comb begin
    wdat = '0;
    for (int i = 0; i < NB; i++) begin
      wdat[i*LW +: 8] = wsrc[i*8 +: 8];
`ifdef MEM_SYNC_DP_PARITY_EN
      wdat[i*LW + 8] = byte_parity(wsrc[i*8 +: 8]) ^ (par_inj & ~init_we);
`endif
    end
  end

  mem_sync_dp_array #(
    .NL(NB), .LW(LW), .DEPTH(DEPTH), .AW(AW), .RDW_MODE(RDW_MODE)
  ) u_array (
    .clk(clk), .we(we), .waddr(waddr), .wbe(wbe), .wdat(wdat),
    .ra_en(a_rreq), .ra_addr(ra_addr), .rb_en(b_acc), .rb_addr(rb_addr),
    .ra_dat(ra_dat), .rb_dat(rb_dat)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) state_d = ST_READY;
    end
    a_v1_d     = a_rreq;
    b_v1_d     = b_acc;
    a_z1_d     = a_rreq ? a_oob : a_z1_q;
    b_z1_d     = b_acc  ? b_oob : b_z1_q;
    addr_err_d = (a_acc & a_oob) | (b_acc & b_oob);
  end

  // z1 resets to 1 so the unreset array registers read as zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      a_v1_q     <= 1'b0;
      b_v1_q     <= 1'b0;
      a_z1_q     <= 1'b1;
      b_z1_q     <= 1'b1;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_v1_q     <= a_v1_d;
      b_v1_q     <= b_v1_d;
      a_z1_q     <= a_z1_d;
      b_z1_q     <= b_z1_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign addr_err = addr_err_q;

  always_comb begin
    a_s1 = '0;
    b_s1 = '0;
`ifdef MEM_SYNC_DP_PARITY_EN
    a_pe1 = 1'b0;
    b_pe1 = 1'b0;
`endif
    for (int i = 0; i < NB; i++) begin
      a_s1[i*8 +: 8] = ra_dat[i*LW +: 8];
      b_s1[i*8 +: 8] = rb_dat[i*LW +: 8];
`ifdef MEM_SYNC_DP_PARITY_EN
      a_pe1 = a_pe1 | (ra_dat[i*LW + 8] ^ byte_parity(ra_dat[i*LW +: 8]));
      b_pe1 = b_pe1 | (rb_dat[i*LW + 8] ^ byte_parity(rb_dat[i*LW +: 8]));
`endif
    end
    if (a_z1_q) begin
      a_s1 = '0;
`ifdef MEM_SYNC_DP_PARITY_EN
      a_pe1 = 1'b0;
`endif
    end
    if (b_z1_q) begin
      b_s1 = '0;
`ifdef MEM_SYNC_DP_PARITY_EN
      b_pe1 = 1'b0;
`endif
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic          a_rv2_q, a_rv2_d, b_rv2_q, b_rv2_d;
    logic [DW-1:0] a_rd2_q, a_rd2_d, b_rd2_q, b_rd2_d;
    always_comb begin
      a_rv2_d = a_v1_q;
      b_rv2_d = b_v1_q;
      a_rd2_d = a_v1_q ? a_s1 : a_rd2_q;
      b_rd2_d = b_v1_q ? b_s1 : b_rd2_q;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        a_rv2_q <= 1'b0;
        b_rv2_q <= 1'b0;
        a_rd2_q <= '0;
        b_rd2_q <= '0;
      end else begin
        a_rv2_q <= a_rv2_d;
        b_rv2_q <= b_rv2_d;
        a_rd2_q <= a_rd2_d;
        b_rd2_q <= b_rd2_d;
      end
    end
    assign a_rvalid = a_rv2_q;
    assign b_rvalid = b_rv2_q;
    assign a_rd     = a_rd2_q;
    assign b_rd     = b_rd2_q;
`ifdef MEM_SYNC_DP_PARITY_EN
    logic a_pe2_q, a_pe2_d, b_pe2_q, b_pe2_d;
    always_comb begin
      a_pe2_d = a_v1_q & a_pe1;
      b_pe2_d = b_v1_q & b_pe1;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        a_pe2_q <= 1'b0;
        b_pe2_q <= 1'b0;
      end else begin
        a_pe2_q <= a_pe2_d;
        b_pe2_q <= b_pe2_d;
      end
    end
    assign a_perr = a_pe2_q;
    assign b_perr = b_pe2_q;
`endif
  end else begin : g_nreg
    assign a_rvalid = a_v1_q;
    assign b_rvalid = b_v1_q;
    assign a_rd     = a_s1;
    assign b_rd     = b_s1;
`ifdef MEM_SYNC_DP_PARITY_EN
    assign a_perr = a_v1_q & a_pe1;
    assign b_perr = b_v1_q & b_pe1;
`endif
  end

endmodule

// File: tb/tb_mem_sync_dp.sv
// Purpose : self-checking bench for mem_sync_dp; two instances (256/read-first/no out reg,
//           200/write-first/out reg) share one random stimulus stream and a behavioural model.
// Latency : model applies 1- or 2-cycle read latency per instance.
// Backpressure: n/a.
module tb_mem_sync_dp;

  localparam int DW = 16;
  localparam int AW = 8;

  typedef struct packed {
    logic          v;
    logic          p;
    logic [DW-1:0] d;
  } resp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, a_en, a_wen, b_en, inj;
  logic [1:0]    a_be;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wd;
  logic [1:0]    ready, a_rvalid, b_rvalid, addr_err;
  logic [DW-1:0] a_rd [2];
  logic [DW-1:0] b_rd [2];
`ifdef MEM_SYNC_DP_PARITY_EN
  logic [1:0]    a_perr, b_perr;
`endif

  mem_sync_dp #(.DEPTH(256)) u_dut0 (
    .clk(clk), .rst(rst), .ready(ready[0]),
    .a_en(a_en), .a_wen(a_wen), .a_be(a_be), .a_addr(a_addr), .a_wd(a_wd),
    .a_rd(a_rd[0]), .a_rvalid(a_rvalid[0]),
    .b_en(b_en), .b_addr(b_addr), .b_rd(b_rd[0]), .b_rvalid(b_rvalid[0]),
`ifdef MEM_SYNC_DP_PARITY_EN
    .par_inj(inj), .a_perr(a_perr[0]), .b_perr(b_perr[0]),
`endif
    .addr_err(addr_err[0])
  );

  mem_sync_dp #(.DEPTH(200), .RDW_MODE(1), .OUT_REG(1), .INIT_VAL(16'hA5C3)) u_dut1 (
    .clk(clk), .rst(rst), .ready(ready[1]),
    .a_en(a_en), .a_wen(a_wen), .a_be(a_be), .a_addr(a_addr), .a_wd(a_wd),
    .a_rd(a_rd[1]), .a_rvalid(a_rvalid[1]),
    .b_en(b_en), .b_addr(b_addr), .b_rd(b_rd[1]), .b_rvalid(b_rvalid[1]),
`ifdef MEM_SYNC_DP_PARITY_EN
    .par_inj(inj), .a_perr(a_perr[1]), .b_perr(b_perr[1]),
`endif
    .addr_err(addr_err[1])
  );

  function automatic int dep(input int k);
    return (k == 0) ? 256 : 200;
  endfunction
  function automatic logic rdw(input int k);
    return (k != 0);
  endfunction
  function automatic int lat(input int k);
    return (k == 0) ? 1 : 2;
  endfunction
  function automatic logic [DW-1:0] ival(input int k);
    return (k == 0) ? 16'h0000 : 16'hA5C3;
  endfunction

  // Reference state: word contents, per-byte "parity corrupted" flags, init progress, output pipes.
  logic [DW-1:0] mm [2][256];
  logic [1:0]    pb [2][256];
  int            cyc [2];
  resp_t         ca_a [2], pa_a [2], ca_b [2], pa_b [2];
  logic [DW-1:0] hold_a [2], hold_b [2];
  logic          err_m [2];
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      resp_t         na, nb;
      logic [DW-1:0] old, mrg;
      logic [1:0]    oldp, mp;
      logic          aoob, boob, rdy, fwd;
      na = '0; nb = '0; old = '0; mrg = '0; oldp = '0; mp = '0;
      if (rst) begin
        cyc[k] = 0;
        ca_a[k] = '0; pa_a[k] = '0; ca_b[k] = '0; pa_b[k] = '0;
        hold_a[k] = '0; hold_b[k] = '0; err_m[k] = 1'b0;
      end else begin
        rdy  = cyc[k] >= dep(k);
        aoob = int'(a_addr) >= dep(k);
        boob = int'(b_addr) >= dep(k);
        err_m[k] = 1'b0;
        if (rdy && a_en) begin
          if (!aoob) begin old = mm[k][a_addr]; oldp = pb[k][a_addr]; end
          mrg = old; mp = oldp;
          for (int i = 0; i < 2; i++) begin
            if (a_be[i]) begin mrg[i*8 +: 8] = a_wd[i*8 +: 8]; mp[i] = inj; end
          end
          na.v = !a_wen || (a_be != 2'b00);
          if (!aoob) begin
            na.d = (a_wen && rdw(k)) ? mrg : old;
            na.p = |((a_wen && rdw(k)) ? mp : oldp);
          end
          err_m[k] = aoob;
        end
        if (rdy && b_en) begin
          nb.v = 1'b1;
          fwd  = a_en && a_wen && !aoob && (a_addr == b_addr) && rdw(k);
          if (!boob) begin
            nb.d = fwd ? mrg : mm[k][b_addr];
            nb.p = |(fwd ? mp : pb[k][b_addr]);
          end
          err_m[k] = err_m[k] | boob;
        end
        if (rdy && a_en && a_wen && !aoob) begin
          mm[k][a_addr] = mrg;
          pb[k][a_addr] = mp;
        end
        if (lat(k) == 2) begin
          ca_a[k] = pa_a[k]; pa_a[k] = na; ca_b[k] = pa_b[k]; pa_b[k] = nb;
        end else begin
          ca_a[k] = na; ca_b[k] = nb;
        end
        if (ca_a[k].v) hold_a[k] = ca_a[k].d;
        if (ca_b[k].v) hold_b[k] = ca_b[k].d;
        // After DEPTH init cycles every word holds the init value with clean parity.
        if (cyc[k] < dep(k)) begin
          cyc[k]++;
          if (cyc[k] == dep(k)) begin
            for (int j = 0; j < 256; j++) begin mm[k][j] = ival(k); pb[k][j] = 2'b00; end
          end
        end
      end
    end
  endtask

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ready%0d", k), ready[k], cyc[k] >= dep(k));
      chk($sformatf("a_rvalid%0d", k), a_rvalid[k], ca_a[k].v);
      chk($sformatf("a_rd%0d", k), a_rd[k], hold_a[k]);
      chk($sformatf("b_rvalid%0d", k), b_rvalid[k], ca_b[k].v);
      chk($sformatf("b_rd%0d", k), b_rd[k], hold_b[k]);
      chk($sformatf("addr_err%0d", k), addr_err[k], err_m[k]);
`ifdef MEM_SYNC_DP_PARITY_EN
      chk($sformatf("a_perr%0d", k), a_perr[k], ca_a[k].v & ca_a[k].p);
      chk($sformatf("b_perr%0d", k), b_perr[k], ca_b[k].v & ca_b[k].p);
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle();
    a_en = 1'b0; a_wen = 1'b0; a_be = 2'b00; a_addr = '0; a_wd = '0;
    b_en = 1'b0; b_addr = '0; inj = 1'b0;
  endtask

  task automatic rnd_inputs();
    a_en   = 1'($urandom_range(0, 1));
    a_wen  = 1'($urandom_range(0, 1));
    a_be   = 2'($urandom_range(0, 3));
    a_addr = 8'($urandom_range(0, 255));
    a_wd   = 16'($urandom);
    b_en   = 1'($urandom_range(0, 1));
    b_addr = ($urandom_range(0, 3) == 0) ? a_addr : 8'($urandom_range(0, 255));
    inj    = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    idle();
    repeat (2) step();
    rst = 1'b0;
    // Requests during INIT must be ignored; reset again at cnt=100.
    for (int i = 0; i < 100; i++) begin rnd_inputs(); step(); end
    rst = 1'b1;
    rnd_inputs();
    step();
    rst = 1'b0;
    n = 0;
    do begin rnd_inputs(); step(); n++; end while (!ready[0] && n < 400);
    chk("init_len", n, 256);

    idle(); b_en = 1'b1; b_addr = 8'd77; step();
    chk("init_rd0", b_rd[0], 16'h0000);

    // Byte-enable merge.
    idle(); a_en = 1'b1; a_wen = 1'b1; a_be = 2'b11; a_addr = 8'd5; a_wd = 16'h1234; step();
    a_be = 2'b01; a_wd = 16'hBEEF; step();
    a_wen = 1'b0; step();
    chk("be_rd0", a_rd[0], 16'h12EF);
    idle(); step();
    chk("be_rd1", a_rd[1], 16'h12EF);

    // Same-address A write / B read.
    a_en = 1'b1; a_wen = 1'b1; a_be = 2'b11; a_addr = 8'd9; a_wd = 16'h5555; step();
    a_wd = 16'hAAAA; b_en = 1'b1; b_addr = 8'd9; step();
    chk("rdw_b0", b_rd[0], 16'h5555);
    idle(); step();
    chk("rdw_b1", b_rd[1], 16'hAAAA);

    // Out-of-range on the 200-word instance.
    a_en = 1'b1; a_addr = 8'd210; step();
    chk("oob_err1", addr_err[1], 1'b1);
    chk("oob_err0", addr_err[0], 1'b0);
    idle(); step();
    chk("oob_v1", a_rvalid[1], 1'b1);
    chk("oob_rd1", a_rd[1], 16'h0000);
    a_en = 1'b1; a_wen = 1'b1; a_be = 2'b11; a_addr = 8'd210; a_wd = 16'hFFFF; step();
    idle(); step();

`ifdef MEM_SYNC_DP_PARITY_EN
    a_en = 1'b1; a_wen = 1'b1; a_be = 2'b11; a_addr = 8'd3; a_wd = 16'h1357; inj = 1'b1; step();
    inj = 1'b0; a_wen = 1'b0; step();
    chk("perr_set", a_perr[0], 1'b1);
    a_wen = 1'b1; step();
    a_wen = 1'b0; step();
    chk("perr_clr", a_perr[0], 1'b0);
    idle(); step();
`endif

    for (int i = 0; i < 3000; i++) begin
      rnd_inputs();
      rst = (i == 1500);
      step();
    end
    rst = 1'b0;
    idle();
    n = 0;
    while (!ready[0] && n < 400) begin step(); n++; end
    chk("reinit_done", ready[0], 1'b1);

    // Sweep every address through B so the model checks all stored words.
    for (int j = 0; j < 256; j++) begin
      b_en = 1'b1; b_addr = 8'(j); step();
    end
    idle();
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
